// File: rtl/smd_map_pkg.sv
// -----------------------------------------------------------------------------
// smd_map_pkg
// Shared constants for the Mega Drive cartridge mapper and any other bus
// register blocks that sit on the /TIME register window.
//   REG_BASE_DEF   default byte address of register 0 (low nibble zero)
//   CTRL_IDX       register index of the BRAM control register
//   CTRL_RAM_ON    bit position of the BRAM map enable in the control register
//   CTRL_WP        bit position of the BRAM write-protect in the control register
//   WE_COMMIT_PAT  synchroniser history that marks a committed write
//   WE_SYNC_RST    synchroniser reset value (looks like a strobe already held)
// -----------------------------------------------------------------------------
package smd_map_pkg;

   localparam logic [23:0] REG_BASE_DEF  = 24'hA130F0;
   localparam int unsigned CTRL_IDX      = 0;
   localparam int unsigned CTRL_RAM_ON   = 0;
   localparam int unsigned CTRL_WP       = 1;

   // Oldest sample low, two newest high: the strobe has been stable for two
   // clk50 samples, so the bus address and data are settled.
   localparam logic [2:0]  WE_COMMIT_PAT = 3'b011;
   localparam logic [2:0]  WE_SYNC_RST   = 3'b111;

   // True when a word address falls inside the 16-byte register window.
   function automatic logic reg_window_hit(input logic [23:1] addr,
                                           input logic [23:0] base);
      return addr[23:4] == base[23:4];
   endfunction

endpackage

// File: rtl/bus_we_sync.sv
// -----------------------------------------------------------------------------
// bus_we_sync
// Samples an asynchronous bus write strobe into the clk50 domain and emits a
// single-cycle commit pulse once the strobe has been high for two samples.
// Strobes shorter than two samples are ignored; a strobe already high when
// reset releases never commits because the history resets to all-ones.
//   clk50   in   system clock
//   rst     in   synchronous reset, active-high
//   strobe  in   raw (unsynchronised) write strobe, active-high
//   commit  out  one-cycle commit pulse
// -----------------------------------------------------------------------------
module bus_we_sync
   import smd_map_pkg::*;
(
   input  logic clk50,
   input  logic rst,
   input  logic strobe,
   output logic commit
);

   logic [2:0] st;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, giving a true shift.
   always_ff @(posedge clk50) begin
      if (rst) begin
         st <= WE_SYNC_RST;
      end else begin
         st <= {st[1:0], strobe};
      end
   end

   // Only the rising-edge history matches, so a long strobe commits once.
   assign commit = (st == WE_COMMIT_PAT);

endmodule

// File: rtl/smd_bank_mapper.sv
// -----------------------------------------------------------------------------
// smd_bank_mapper
// Mega Drive cartridge mapper: splits the 4 MB cart space into NUM_BANKS
// equal windows, each remapped through a bank register, and maps BRAM into
// the upper half when enabled. Registers live at REG_BASE (idx = addr[3:1]):
//   idx 0            control: bit0 ram_on, bit1 ram_wp
//   idx 1..NUM-1     bank register for that window (window 0 is fixed at 0)
// Optional build macro: MAP_REGREAD_EN adds combinational register readback.
//   clk50        in   system clock
//   rst          in   synchronous reset, active-high
//   addr         in   CPU word address [23:1]
//   data_in      in   CPU data bus
//   as_n         in   address strobe, active-low
//   ce_lo_n      in   cart space select, active-low
//   oe_n         in   CPU read strobe, active-low
//   we_lo_n      in   low-byte write strobe, active-low
//   rom_ce       out  ROM PSRAM select
//   rom_addr     out  physical PSRAM word address
//   ram_ce       out  BRAM select
//   ram_we_en    out  BRAM write permitted
//   ram_on       out  BRAM mapped into its window
//   ram_wp       out  BRAM write-protect
//   reg_rd_oe    out  register readback drive enable (0 without the macro)
//   reg_rd_data  out  register readback data (0 without the macro)
// -----------------------------------------------------------------------------
module smd_bank_mapper
   import smd_map_pkg::*;
#(
   parameter int          NUM_BANKS  = 8,
   parameter int          BANK_W     = 6,
   parameter logic [23:0] REG_BASE   = REG_BASE_DEF,
   parameter logic        RAM_ON_RST = 1'b0,
   localparam int         WIN_BITS   = $clog2(NUM_BANKS),
   localparam int         WIN_OFF    = 21 - WIN_BITS
)(
   input  logic                      clk50,
   input  logic                      rst,
   input  logic [23:1]               addr,
   input  logic [15:0]               data_in,
   input  logic                      as_n,
   input  logic                      ce_lo_n,
   input  logic                      oe_n,
   input  logic                      we_lo_n,
   output logic                      rom_ce,
   output logic [BANK_W+WIN_OFF-1:0] rom_addr,
   output logic                      ram_ce,
   output logic                      ram_we_en,
   output logic                      ram_on,
   output logic                      ram_wp,
   output logic                      reg_rd_oe,
   output logic [15:0]               reg_rd_data
);

   logic                reg_sel;
   logic                wr_raw;
   logic                wr_commit;
   logic [2:0]          idx;
   logic [BANK_W-1:0]   bank_reg [NUM_BANKS];
   logic [WIN_BITS-1:0] win;
   logic                cart_ce;

   assign reg_sel = reg_window_hit(addr, REG_BASE);
   assign wr_raw  = !we_lo_n & !as_n & reg_sel;
   assign idx     = addr[3:1];

   bus_we_sync u_we_sync (
      .clk50  (clk50),
      .rst    (rst),
      .strobe (wr_raw),
      .commit (wr_commit)
   );

   // NOTE: the bank file is a handful of flops, not a RAM macro, so it is
   // reset to the identity map; software may rely on that power-on layout.
   always_ff @(posedge clk50) begin
      if (rst) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            bank_reg[i] <= BANK_W'(i);
         end
         ram_on <= RAM_ON_RST;
         ram_wp <= 1'b0;
      end else if (wr_commit) begin
         if (idx == 3'(CTRL_IDX)) begin
            ram_on <= data_in[CTRL_RAM_ON];
            ram_wp <= data_in[CTRL_WP];
         end
         // Window 0 stays at bank 0 so the vector table is always reachable.
         for (int i = 1; i < NUM_BANKS; i++) begin
            if (idx == 3'(i)) begin
               bank_reg[i] <= data_in[BANK_W-1:0];
            end
         end
      end
   end

   // addr[23:22] are not decoded, so the 4 MB space mirrors.
   assign cart_ce   = !ce_lo_n;
   assign win       = addr[21:WIN_OFF+1];
   assign ram_ce    = cart_ce & addr[21] & ram_on;
   assign rom_ce    = cart_ce & !ram_ce;
   assign rom_addr  = {bank_reg[win], addr[WIN_OFF:1]};
   assign ram_we_en = ram_ce & !ram_wp;

`ifdef MAP_REGREAD_EN
   assign reg_rd_oe = !oe_n & !as_n & reg_sel;

   // NOTE: every output of a combinational block gets a default first so no
   // path through the selects leaves it holding state (no latch).
   always_comb begin
      reg_rd_data = '0;
      if (idx == 3'(CTRL_IDX)) begin
         reg_rd_data[CTRL_RAM_ON] = ram_on;
         reg_rd_data[CTRL_WP]     = ram_wp;
      end
      for (int i = 1; i < NUM_BANKS; i++) begin
         if (idx == 3'(i)) begin
            reg_rd_data = 16'(bank_reg[i]);
         end
      end
   end
`else
   assign reg_rd_oe   = 1'b0;
   assign reg_rd_data = '0;

   // The read strobe only matters to the readback path.
   logic unused_oe;
   assign unused_oe = oe_n;
`endif

   // Upper data bits are ignored by every register.
   logic unused_data;
   assign unused_data = &{1'b0, data_in[15:BANK_W]};

endmodule

// File: tb/tb_smd_bank_mapper.sv
// -----------------------------------------------------------------------------
// tb_smd_bank_mapper
// Self-checking bench for smd_bank_mapper with default geometry (8 windows of
// 512 KB, 6-bit banks). Expected bus outputs come from an arithmetic model of
// the address map; register writes update the model only when the strobe is
// long enough to commit. Build with or without MAP_REGREAD_EN.
// -----------------------------------------------------------------------------
module tb_smd_bank_mapper;

   localparam int          NUM_BANKS = 8;
   localparam int          BANK_W    = 6;
   localparam int          WIN_OFF   = 21 - $clog2(NUM_BANKS);
   localparam logic [23:0] REG_BASE  = 24'hA130F0;

   typedef struct packed {
      logic        rom_ce;
      logic        ram_ce;
      logic        ram_we_en;
      logic        ram_on;
      logic        ram_wp;
      logic [23:0] rom_addr;
      logic        reg_rd_oe;
      logic [15:0] reg_rd_data;
   } obs_t;

   logic                      clk50;
   logic                      rst;
   logic [23:1]               addr;
   logic [15:0]               data_in;
   logic                      as_n;
   logic                      ce_lo_n;
   logic                      oe_n;
   logic                      we_lo_n;
   logic                      rom_ce;
   logic [BANK_W+WIN_OFF-1:0] rom_addr;
   logic                      ram_ce;
   logic                      ram_we_en;
   logic                      ram_on;
   logic                      ram_wp;
   logic                      reg_rd_oe;
   logic [15:0]               reg_rd_data;

   int checks   = 0;
   int failures = 0;

   // Reference state: what software believes the registers hold.
   int unsigned m_bank [NUM_BANKS];
   bit          m_on;
   bit          m_wp;

   smd_bank_mapper #(
      .NUM_BANKS  (NUM_BANKS),
      .BANK_W     (BANK_W),
      .REG_BASE   (REG_BASE),
      .RAM_ON_RST (1'b0)
   ) dut (
      .clk50       (clk50),
      .rst         (rst),
      .addr        (addr),
      .data_in     (data_in),
      .as_n        (as_n),
      .ce_lo_n     (ce_lo_n),
      .oe_n        (oe_n),
      .we_lo_n     (we_lo_n),
      .rom_ce      (rom_ce),
      .rom_addr    (rom_addr),
      .ram_ce      (ram_ce),
      .ram_we_en   (ram_we_en),
      .ram_on      (ram_on),
      .ram_wp      (ram_wp),
      .reg_rd_oe   (reg_rd_oe),
      .reg_rd_data (reg_rd_data)
   );

   initial clk50 = 1'b0;
   always #10 clk50 = ~clk50;

   // ---------------------------------------------------------------- model
   function automatic void m_reset();
      for (int i = 0; i < NUM_BANKS; i++) m_bank[i] = i;
      m_on = 1'b0;
      m_wp = 1'b0;
   endfunction

   function automatic void m_write(input int unsigned idx, input int unsigned data);
      if (idx == 0) begin
         m_on = data[0];
         m_wp = data[1];
      end else if (idx < NUM_BANKS) begin
         m_bank[idx] = data % (1 << BANK_W);
      end
   endfunction

   function automatic obs_t model(input int unsigned ba, input bit ce_lo, input bit oe);
      obs_t        e;
      int unsigned win;
      int unsigned off;
      int unsigned idx;
      bit          cart;
      bit          hit;
      cart = !ce_lo;
      win  = (ba >> (WIN_OFF + 1)) % NUM_BANKS;
      off  = (ba >> 1) % (1 << WIN_OFF);
      idx  = (ba >> 1) % 8;
      hit  = ((ba % (1 << 24)) >> 4) == (REG_BASE >> 4);
      e.ram_ce      = cart && (((ba >> 21) % 2) == 1) && m_on;
      e.rom_ce      = cart && !e.ram_ce;
      e.ram_we_en   = e.ram_ce && !m_wp;
      e.ram_on      = m_on;
      e.ram_wp      = m_wp;
      e.rom_addr    = 24'(m_bank[win] * (1 << WIN_OFF) + off);
      e.reg_rd_oe   = 1'b0;
      e.reg_rd_data = 16'd0;
`ifdef MAP_REGREAD_EN
      e.reg_rd_oe = hit && !oe;
      if (idx == 0)              e.reg_rd_data = 16'(m_wp * 2 + m_on);
      else if (idx < NUM_BANKS)  e.reg_rd_data = 16'(m_bank[idx]);
`else
      if (hit) e.reg_rd_oe = 1'b0;
`endif
      return e;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("rom_ce=%0b ram_ce=%0b we_en=%0b on=%0b wp=%0b rom_addr=%h rd_oe=%0b rd_data=%h",
                       o.rom_ce, o.ram_ce, o.ram_we_en, o.ram_on, o.ram_wp,
                       o.rom_addr, o.reg_rd_oe, o.reg_rd_data);
   endfunction

   // ------------------------------------------------------------ bus drivers
   // Present a read cycle at the falling edge and capture outputs 2 ns later.
   task automatic probe(input logic [23:0] ba, input bit ce_lo, input bit oe, output obs_t o);
      @(negedge clk50);
      addr    = ba[23:1];
      ce_lo_n = ce_lo;
      oe_n    = oe;
      as_n    = 1'b0;
      we_lo_n = 1'b1;
      #2;
      o = '{rom_ce, ram_ce, ram_we_en, ram_on, ram_wp, 24'(rom_addr), reg_rd_oe, reg_rd_data};
   endtask

   // Hold a register write strobe for `hold` clock samples, then idle long
   // enough for the synchroniser to drain. Address/data stay on the bus.
   task automatic write_reg(input int unsigned idx, input logic [15:0] data, input int hold);
      @(negedge clk50);
      addr    = REG_BASE[23:1] + 23'(idx);
      data_in = data;
      ce_lo_n = 1'b1;
      oe_n    = 1'b1;
      as_n    = 1'b0;
      we_lo_n = 1'b0;
      repeat (hold) @(negedge clk50);
      as_n    = 1'b1;
      we_lo_n = 1'b1;
      repeat (3) @(negedge clk50);
   endtask

   task automatic do_reset();
      @(negedge clk50);
      rst = 1'b1;
      repeat (2) @(negedge clk50);
      rst = 1'b0;
      m_reset();
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      obs_t o, e;
      do_reset();
      probe(24'h080000, 1'b0, 1'b0, o);
      checks++;
      if (o.rom_addr !== 24'h040000 || o.ram_on !== 1'b0 || o.ram_wp !== 1'b0) begin
         failures++;
         $display("FAIL reset_win1: got rom_addr=%h on=%0b wp=%0b expected rom_addr=040000 on=0 wp=0",
                  o.rom_addr, o.ram_on, o.ram_wp);
      end
      for (int w = 0; w < NUM_BANKS; w++) begin
         logic [23:0] ba;
         ba = 24'(w << (WIN_OFF + 1)) | 24'h000126;
         probe(ba, 1'b0, 1'b1, o);
         e = model(ba, 1'b0, 1'b1);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL reset_map w%0d: got %s expected %s", w, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_bank_write();
      obs_t o, e;
      write_reg(1, 16'h0005, 4);
      m_write(1, 16'h0005);
      probe(24'h080002, 1'b0, 1'b0, o);
      checks++;
      if (o.rom_addr !== {6'd5, 18'd1} || o.rom_ce !== 1'b1) begin
         failures++;
         $display("FAIL bank1_write: got rom_addr=%h rom_ce=%0b expected rom_addr=%h rom_ce=1",
                  o.rom_addr, o.rom_ce, {6'd5, 18'd1});
      end
      // Oversized bank value truncates to BANK_W bits.
      write_reg(4, 16'hFFC5, 3);
      m_write(4, 16'hFFC5);
      probe(24'h21FFFE, 1'b0, 1'b0, o);
      e = model(24'h21FFFE, 1'b0, 1'b0);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL bank4_trunc: got %s expected %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_ram_ctrl();
      obs_t o, e;
      write_reg(0, 16'h0003, 4);
      m_write(0, 16'h0003);
      probe(24'h200000, 1'b0, 1'b0, o);
      checks++;
      if (o.ram_ce !== 1'b1 || o.rom_ce !== 1'b0 || o.ram_we_en !== 1'b0) begin
         failures++;
         $display("FAIL ram_wp_on: got ram_ce=%0b rom_ce=%0b we_en=%0b expected 1 0 0",
                  o.ram_ce, o.rom_ce, o.ram_we_en);
      end
      write_reg(0, 16'h0001, 4);
      m_write(0, 16'h0001);
      probe(24'h200000, 1'b0, 1'b0, o);
      checks++;
      if (o.ram_ce !== 1'b1 || o.rom_ce !== 1'b0 || o.ram_we_en !== 1'b1) begin
         failures++;
         $display("FAIL ram_wp_off: got ram_ce=%0b rom_ce=%0b we_en=%0b expected 1 0 1",
                  o.ram_ce, o.rom_ce, o.ram_we_en);
      end
      // Window 0 is still bank 0 and the lower half stays ROM.
      probe(24'h000404, 1'b0, 1'b0, o);
      e = model(24'h000404, 1'b0, 1'b0);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL ram_low_rom: got %s expected %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_glitch();
      obs_t o, e;
      write_reg(2, 16'h0015, 1);
      probe(24'h100000, 1'b0, 1'b1, o);
      e = model(24'h100000, 1'b0, 1'b1);
      checks++;
      if (o.rom_addr !== {6'd2, 18'd0} || o !== e) begin
         failures++;
         $display("FAIL glitch_ignored: got %s expected %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_back_to_back();
      obs_t o, e;
      logic [15:0] vals [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h000C};
      // Data changes every cycle of a 4-sample strobe: only the value on the
      // bus during the commit cycle (third) may land, and only once.
      @(negedge clk50);
      addr    = REG_BASE[23:1] + 23'd5;
      ce_lo_n = 1'b1;
      oe_n    = 1'b1;
      as_n    = 1'b0;
      we_lo_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         data_in = vals[k];
         @(negedge clk50);
      end
      as_n    = 1'b1;
      we_lo_n = 1'b1;
      repeat (3) @(negedge clk50);
      m_write(5, 16'h0033);
      probe(24'h280000, 1'b0, 1'b1, o);
      e = model(24'h280000, 1'b0, 1'b1);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL single_commit: got %s expected %s", fmt(o), fmt(e));
      end
      write_reg(6, 16'h0017, 2);
      write_reg(7, 16'h0028, 2);
      m_write(6, 16'h0017);
      m_write(7, 16'h0028);
      for (int w = 6; w < 8; w++) begin
         logic [23:0] ba;
         ba = 24'(w << (WIN_OFF + 1)) | 24'h00ABCE;
         probe(ba, 1'b0, 1'b1, o);
         e = model(ba, 1'b0, 1'b1);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL b2b_w%0d: got %s expected %s", w, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_reset_hold();
      obs_t o, e;
      // Strobe asserted before reset and held through its release.
      @(negedge clk50);
      addr    = REG_BASE[23:1] + 23'd2;
      data_in = 16'h0011;
      ce_lo_n = 1'b1;
      as_n    = 1'b0;
      we_lo_n = 1'b0;
      rst     = 1'b1;
      repeat (2) @(negedge clk50);
      rst = 1'b0;
      m_reset();
      repeat (4) @(negedge clk50);
      as_n    = 1'b1;
      we_lo_n = 1'b1;
      repeat (3) @(negedge clk50);
      probe(24'h100000, 1'b0, 1'b1, o);
      e = model(24'h100000, 1'b0, 1'b1);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL hold_thru_rst: got %s expected %s", fmt(o), fmt(e));
      end
      write_reg(2, 16'h0011, 3);
      m_write(2, 16'h0011);
      probe(24'h100000, 1'b0, 1'b1, o);
      e = model(24'h100000, 1'b0, 1'b1);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL reassert_commit: got %s expected %s", fmt(o), fmt(e));
      end
      // Reset arriving in the commit cycle wins.
      @(negedge clk50);
      addr    = REG_BASE[23:1] + 23'd3;
      data_in = 16'h003F;
      as_n    = 1'b0;
      we_lo_n = 1'b0;
      repeat (2) @(negedge clk50);
      rst = 1'b1;
      @(negedge clk50);
      rst     = 1'b0;
      as_n    = 1'b1;
      we_lo_n = 1'b1;
      m_reset();
      repeat (3) @(negedge clk50);
      probe(24'h180000, 1'b0, 1'b1, o);
      e = model(24'h180000, 1'b0, 1'b1);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL rst_wins: got %s expected %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_regread();
      obs_t o, e;
      write_reg(3, 16'h002A, 3);
      m_write(3, 16'h002A);
      probe(REG_BASE + 24'd6, 1'b1, 1'b0, o);
      e = model(REG_BASE + 24'd6, 1'b1, 1'b0);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL regread_idx3: got %s expected %s", fmt(o), fmt(e));
      end
      write_reg(0, 16'hFFFE, 3);
      m_write(0, 16'hFFFE);
      probe(REG_BASE, 1'b1, 1'b0, o);
      e = model(REG_BASE, 1'b1, 1'b0);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL regread_ctrl: got %s expected %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_random();
      obs_t o, e;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(1, 0) == 1) begin
            int unsigned idx;
            logic [15:0] d;
            int          hold;
            idx  = $urandom_range(7, 0);
            d    = 16'($urandom);
            hold = $urandom_range(5, 1);
            write_reg(idx, d, hold);
            if (hold >= 2) m_write(idx, d);
         end
         for (int p = 0; p < 3; p++) begin
            logic [23:0] ba;
            bit          ce_lo;
            bit          oe;
            if ($urandom_range(3, 0) == 0) ba = REG_BASE + 24'($urandom_range(7, 0) * 2);
            else                           ba = 24'($urandom) & 24'hFFFFFE;
            ce_lo = ($urandom_range(3, 0) == 0);
            oe    = ($urandom_range(1, 0) == 1);
            probe(ba, ce_lo, oe, o);
            e = model(ba, ce_lo, oe);
            checks++;
            if (o !== e) begin
               failures++;
               $display("FAIL random it%0d addr=%h: got %s expected %s", it, ba, fmt(o), fmt(e));
            end
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      addr    = '0;
      data_in = '0;
      as_n    = 1'b1;
      ce_lo_n = 1'b1;
      oe_n    = 1'b1;
      we_lo_n = 1'b1;
      m_reset();
      test_reset();
      test_bank_write();
      test_ram_ctrl();
      test_glitch();
      test_back_to_back();
      test_reset_hold();
      test_regread();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
